// File: rtl/core_fetch_queue_pkg.sv
// Shared core definitions for the fetch queue: the NOP used to fill an empty decode slot,
// the queue entry layout, and a PC alignment helper.
package core_fetch_queue_pkg;

  // Widest PC the entry layout can hold; narrower cores zero-extend into it.
  localparam int PC_STORE_W = 64;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [PC_STORE_W-1:0] pc;
    logic [31:0]           instr;
    logic                  misaligned;
  } fetch_entry_t;

  function automatic logic pc_misaligned(input logic [1:0] pc_lo);
    return |pc_lo;
  endfunction

endpackage

// File: rtl/core_fetch_queue.sv
// First-word-fall-through queue between instruction memory responses and decode.
// Storage, pointers and occupancy count live here; flush and reset clear only the control state.
module core_fetch_queue
  import core_fetch_queue_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_flush,
  input  logic                       i_imem_valid,
  input  logic [XLEN-1:0]            i_imem_pc,
  input  logic [31:0]                i_imem_instr,
  output logic                       o_imem_ready,
  output logic                       o_pc_write,
  output logic                       o_id_valid,
  output logic [XLEN-1:0]            o_id_pc,
  output logic [31:0]                o_id_instr,
  output logic                       o_id_misaligned,
  input  logic                       i_id_ready,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] CNT_FULL     = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE_LEFT = CNT_W'(DEPTH - 1);

  fetch_entry_t       r_mem [DEPTH];
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [CNT_W-1:0]   r_count;

  logic               w_empty;
  logic               w_full;
  logic               w_push;
  logic               w_pop;
  fetch_entry_t       w_wr_entry;
  fetch_entry_t       w_head;
  logic               w_unused_pc_hi;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_FULL);

  // Ready and pc_write depend only on registered count (and the response valid),
  // never on i_id_ready, so there is no decode-to-memory combinational path.
  assign o_imem_ready = !w_full;
  assign o_id_valid   = !w_empty;
  assign o_pc_write   = (r_count < CNT_ONE_LEFT) ||
                        ((r_count == CNT_ONE_LEFT) && !i_imem_valid);
  assign o_count      = r_count;

  // A full queue never pushes, so push and pop cannot coincide when full.
  assign w_push = i_imem_valid && o_imem_ready && !i_flush;
  assign w_pop  = o_id_valid && i_id_ready && !i_flush;

  always_comb begin
    w_wr_entry            = '0;
    w_wr_entry.pc         = PC_STORE_W'(i_imem_pc);
    w_wr_entry.instr      = i_imem_instr;
    w_wr_entry.misaligned = pc_misaligned(i_imem_pc[1:0]);
  end

  // Storage is never reset or cleared; the count gates every read of it.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_wr_entry;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head         = r_mem[r_rd_ptr];
  assign w_unused_pc_hi = ^w_head.pc;

  always_comb begin
    o_id_pc         = '0;
    o_id_instr      = NOP_INSTR;
    o_id_misaligned = 1'b0;
    if (!w_empty) begin
      o_id_pc         = w_head.pc[XLEN-1:0];
      o_id_instr      = w_head.instr;
      o_id_misaligned = w_head.misaligned;
    end
  end

endmodule

// File: tb/tb_core_fetch_queue.sv
// Self-checking bench for core_fetch_queue: directed scenarios plus randomized traffic,
// all compared against a queue-based behavioural model.
module tb_core_fetch_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              i_clk = 1'b0;
  logic              i_rst_n;
  logic              i_flush;
  logic              i_imem_valid;
  logic [XLEN-1:0]   i_imem_pc;
  logic [31:0]       i_imem_instr;
  logic              o_imem_ready;
  logic              o_pc_write;
  logic              o_id_valid;
  logic [XLEN-1:0]   o_id_pc;
  logic [31:0]       o_id_instr;
  logic              o_id_misaligned;
  logic              i_id_ready;
  logic [CNT_W-1:0]  o_count;

  always #5 i_clk = ~i_clk;

  core_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_flush         (i_flush),
    .i_imem_valid    (i_imem_valid),
    .i_imem_pc       (i_imem_pc),
    .i_imem_instr    (i_imem_instr),
    .o_imem_ready    (o_imem_ready),
    .o_pc_write      (o_pc_write),
    .o_id_valid      (o_id_valid),
    .o_id_pc         (o_id_pc),
    .o_id_instr      (o_id_instr),
    .o_id_misaligned (o_id_misaligned),
    .i_id_ready      (i_id_ready),
    .o_count         (o_count)
  );

  typedef struct {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } ent_t;

  ent_t mq[$];
  int   n_err = 0;
  int   n_chk = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_outputs(input string where);
    int n;
    n = mq.size();
    chk({where, " valid"}, 64'(o_id_valid), 64'(n != 0));
    chk({where, " count"}, 64'(o_count), 64'(n));
    chk({where, " imem_ready"}, 64'(o_imem_ready), 64'(n != DEPTH));
    chk({where, " pc_write"}, 64'(o_pc_write),
        64'((n < DEPTH - 1) || (n == DEPTH - 1 && !i_imem_valid)));
    if (n == 0) begin
      chk({where, " instr"}, 64'(o_id_instr), 64'h13);
      chk({where, " pc"}, 64'(o_id_pc), 64'h0);
      chk({where, " misaligned"}, 64'(o_id_misaligned), 64'h0);
    end else begin
      chk({where, " instr"}, 64'(o_id_instr), 64'(mq[0].instr));
      chk({where, " pc"}, 64'(o_id_pc), 64'(mq[0].pc));
      chk({where, " misaligned"}, 64'(o_id_misaligned), 64'(mq[0].pc[1:0] != 2'b00));
    end
  endtask

  // Drive one cycle of inputs, check the presented outputs, clock, then update the model.
  task automatic step(input logic v, input logic [XLEN-1:0] pc, input logic [31:0] ins,
                      input logic rdy, input logic fl, input string tag);
    logic push, pop;
    i_imem_valid = v;
    i_imem_pc    = pc;
    i_imem_instr = ins;
    i_id_ready   = rdy;
    i_flush      = fl;
    #1;
    check_outputs(tag);
    push = v && (mq.size() < DEPTH) && !fl;
    pop  = (mq.size() > 0) && rdy && !fl;
    @(posedge i_clk);
    if (fl) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back('{pc: pc, instr: ins});
    end
    #1;
  endtask

  initial begin
    logic            hold_v;
    logic [XLEN-1:0] hold_pc;
    logic [31:0]     hold_ins;

    i_rst_n      = 1'b0;
    i_flush      = 1'b0;
    i_imem_valid = 1'b0;
    i_imem_pc    = '0;
    i_imem_instr = '0;
    i_id_ready   = 1'b0;
    #12;
    check_outputs("reset");
    chk("reset pc_write", 64'(o_pc_write), 64'h1);
    chk("reset instr", 64'(o_id_instr), 64'h0000_0013);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    // Single push becomes visible one cycle later.
    step(1'b1, 32'h4000_0000, 32'h0010_0093, 1'b0, 1'b0, "push1");
    chk("push1 valid", 64'(o_id_valid), 64'h1);
    chk("push1 pc", 64'(o_id_pc), 64'h4000_0000);
    chk("push1 count", 64'(o_count), 64'h1);
    step(1'b0, '0, '0, 1'b0, 1'b1, "clr1");

    // Fill with decode stalled.
    step(1'b1, 32'h4000_0000, 32'h0010_0093, 1'b0, 1'b0, "fill_a");
    step(1'b1, 32'h4000_0004, 32'h0020_0113, 1'b0, 1'b0, "fill_b");
    chk("full count", 64'(o_count), 64'h2);
    chk("full imem_ready", 64'(o_imem_ready), 64'h0);
    chk("full pc_write", 64'(o_pc_write), 64'h0);
    chk("full head", 64'(o_id_pc), 64'h4000_0000);

    // Full with a response waiting: pop only, then push+pop across the pointer wrap.
    step(1'b1, 32'h4000_0008, 32'h0030_0193, 1'b1, 1'b0, "full_pop");
    chk("full_pop count", 64'(o_count), 64'h1);
    chk("full_pop head", 64'(o_id_pc), 64'h4000_0004);
    step(1'b1, 32'h4000_0008, 32'h0030_0193, 1'b1, 1'b0, "pushpop1");
    chk("pushpop1 count", 64'(o_count), 64'h1);
    chk("pushpop1 head", 64'(o_id_instr), 64'h0030_0193);
    step(1'b1, 32'h4000_000C, 32'h0040_0213, 1'b1, 1'b0, "pushpop2");
    chk("pushpop2 head", 64'(o_id_pc), 64'h4000_000C);
    step(1'b0, '0, '0, 1'b1, 1'b0, "drain");

    // Flush beats a simultaneous push.
    step(1'b1, 32'h4000_0010, 32'h0050_0293, 1'b0, 1'b0, "f_a");
    step(1'b1, 32'h4000_0014, 32'h0060_0313, 1'b0, 1'b0, "f_b");
    step(1'b1, 32'hDEAD_0000, 32'hDEAD_BEEF, 1'b1, 1'b1, "flush");
    chk("flush count", 64'(o_count), 64'h0);
    chk("flush valid", 64'(o_id_valid), 64'h0);
    chk("flush instr", 64'(o_id_instr), 64'h0000_0013);
    step(1'b0, '0, '0, 1'b1, 1'b0, "post_flush");

    // Misaligned head flag.
    step(1'b1, 32'h4000_0002, 32'h0070_0393, 1'b0, 1'b0, "mis");
    chk("mis flag", 64'(o_id_misaligned), 64'h1);
    step(1'b0, '0, '0, 1'b1, 1'b0, "mis_pop");
    chk("mis cleared", 64'(o_id_misaligned), 64'h0);

    // Asynchronous reset mid-operation.
    step(1'b1, 32'h4000_0020, 32'h0080_0413, 1'b0, 1'b0, "pre_rst");
    i_imem_valid = 1'b0;
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("async_rst valid", 64'(o_id_valid), 64'h0);
    chk("async_rst count", 64'(o_count), 64'h0);
    mq.delete();
    check_outputs("async_rst");
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    // Randomized traffic; an unaccepted response is held by the responder.
    hold_v = 1'b0;
    hold_pc = '0;
    hold_ins = '0;
    for (int i = 0; i < 400; i++) begin
      logic v, rdy, fl, accepted;
      logic [XLEN-1:0] pc;
      logic [31:0] ins;
      if (hold_v) begin
        v = 1'b1; pc = hold_pc; ins = hold_ins;
      end else begin
        v   = ($urandom_range(0, 9) < 6);
        pc  = $urandom;
        if ($urandom_range(0, 3) != 0) pc[1:0] = 2'b00;
        ins = $urandom;
      end
      rdy = $urandom_range(0, 1);
      fl  = ($urandom_range(0, 15) == 0);
      accepted = v && (mq.size() < DEPTH) && !fl;
      step(v, pc, ins, rdy, fl, "rand");
      hold_v   = v && !accepted && !fl;
      hold_pc  = pc;
      hold_ins = ins;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
